simd_lane_array: RTL
====================

# simd_lane_array

Parametrised successor to the fixed ten-lane SIMD datapath. It holds an internal operand memory of LANES packed lines, each carrying two DATA_W-bit operands (high half A, low half B). On a start request it sweeps every line with one shared ALU, one lane per cycle, and writes a per-lane result register bank. It sits between the operand loader, which writes lines, and the result consumer, which reads the flat result bus after `done`.

## Interface
- LANES, 10, number of lanes / memory lines (2..64)
- DATA_W, 16, operand and result width in bits
- ADDR_W, 6, memory address width; must satisfy 2^ADDR_W >= LANES
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one operand line
- wr_addr  in  ADDR_W  line index
- wr_data  in  2*DATA_W  {A[2*DATA_W-1:DATA_W], B[DATA_W-1:0]}
- start  in  1  begin a sweep (level sampled in IDLE)
- opcode  in  2  00 add, 01 max, 10 xor, 11 min
- busy  out  1  high while a sweep is in progress (RUN or DONE)
- done  out  1  one-cycle pulse when all lanes are written
- result  out  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- ovf  out  LANES  per-lane carry-out of add; 0 for other ops

## Operation
- Reset: state IDLE, index 0, all memory lines 0, result 0, ovf 0, busy 0, done 0. A reset mid-sweep aborts the sweep immediately with the same values.
- FSM states:
  - IDLE: when start=1, latch opcode, clear ovf, set index 0, go to RUN.
  - RUN: each cycle compute lane `index` from mem[index] and write result[index] and ovf[index]. If index==LANES-1, go to DONE; otherwise increment index.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- ALU, with A and B unsigned:
  - add: (A+B) mod 2^DATA_W; ovf = carry out.
  - max: A>=B ? A : B.
  - xor: A^B.
  - min: A<=B ? A : B.
- The latched opcode is used for the whole sweep. Changes on `opcode` during RUN have no effect.
- Writes are accepted only in IDLE with wr_addr < LANES. Writes while busy, or with wr_addr >= LANES, are dropped silently and leave memory unchanged.
- If wr_en and start are asserted in the same IDLE cycle, the write is committed first. The sweep sees the new line.
- start asserted while busy is ignored. It is not queued.
- Results are not cleared at start. Lane i holds its previous value until it is rewritten in RUN cycle i. Between sweeps, result and ovf hold their values.

## Timing
- Edge T samples start=1 in IDLE. busy rises after T.
- RUN edges T+1 .. T+LANES write lanes 0 .. LANES-1, one lane per edge.
- done and busy are high in the cycle after edge T+LANES. busy falls and done clears at edge T+LANES+1.
- Total latency from start to done is LANES+1 cycles. The earliest next start is sampled at edge T+LANES+2 (back-to-back period LANES+2).
- result, ovf, busy and done are all registered outputs with no combinational input-to-output paths.
- The memory read is combinational within a RUN cycle.

## Test plan
- Reset, then load line 0 = {16'h0003, 16'h0005} and line 9 = {16'hFFFF, 16'h0002}, then start with add. Required: done pulses exactly 11 cycles after start; lane0=16'h0008 with ovf[0]=0; lane9=16'h0001 with ovf[9]=1; all unwritten lanes = 0.
- Same memory, start with max, then start with min. Required: max gives lane0=5, lane9=FFFF; min gives lane0=3, lane9=2; ovf=0 after both sweeps.
- Load line 4 = {16'hA5A5, 16'h0F0F}, start with xor. Required: lane4=16'hAAAA.
- During a sweep, pulse start, change opcode and write line 0 = {16'h1111, 16'h1111}. Required: none of these take effect; results match the original sweep exactly; a later IDLE readback sweep with add shows lane0 unchanged.
- Write to wr_addr=12 with LANES=10. Required: memory is unchanged and no X appears on any output.
- Assert rst_n=0 at RUN index 5. Required: busy, done, result and ovf go to 0 asynchronously; after release, a new add sweep of all-zero memory gives all lanes 0.

Source files
------------

// File: rtl/simd_lane_array_if.sv
// Operand-load / sweep-control / result bus of simd_lane_array.
// The DUT side is the slave modport; the loader/consumer side is the master modport.
interface simd_lane_array_if #(
    parameter int unsigned LANES  = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
);
    logic                    i_wr_en;
    logic [ADDR_W-1:0]       i_wr_addr;
    logic [2*DATA_W-1:0]     i_wr_data;
    logic                    i_start;
    logic [1:0]              i_opcode;
    logic                    o_busy;
    logic                    o_done;
    logic [LANES*DATA_W-1:0] o_result;
    logic [LANES-1:0]        o_ovf;

    modport slave (
        input  i_wr_en,
        input  i_wr_addr,
        input  i_wr_data,
        input  i_start,
        input  i_opcode,
        output o_busy,
        output o_done,
        output o_result,
        output o_ovf
    );

    modport master (
        output i_wr_en,
        output i_wr_addr,
        output i_wr_data,
        output i_start,
        output i_opcode,
        input  o_busy,
        input  o_done,
        input  o_result,
        input  o_ovf
    );
endinterface

// File: rtl/simd_lane_array.sv
// Parametrised SIMD lane array: one shared ALU sweeps LANES operand lines, one lane per cycle,
// into a registered per-lane result bank with add carry-out flags.
module simd_lane_array #(
    parameter int unsigned LANES  = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input logic               clk,
    input logic               rst_n,
    simd_lane_array_if.slave  bus
);

    localparam logic [1:0] OpAdd = 2'b00;
    localparam logic [1:0] OpMax = 2'b01;
    localparam logic [1:0] OpXor = 2'b10;
    localparam logic [1:0] OpMin = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  r_state;
    logic [ADDR_W-1:0]       r_idx;
    logic [1:0]              r_op;
    logic [2*DATA_W-1:0]     r_mem [LANES];
    logic [LANES*DATA_W-1:0] r_result;
    logic [LANES-1:0]        r_ovf;
    logic                    r_busy;
    logic                    r_done;

    logic [2*DATA_W-1:0]     w_line;
    logic [DATA_W-1:0]       w_a;
    logic [DATA_W-1:0]       w_b;
    logic [DATA_W:0]         w_sum;
    logic [DATA_W-1:0]       w_alu;
    logic                    w_carry;
    logic                    w_wr_ok;
    logic                    w_last;

    // Explicit per-line compare keeps the read mux free of out-of-range indexing.
    always_comb begin
        w_line = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == ADDR_W'(i)) begin
                w_line = r_mem[i];
            end
        end
    end

    assign w_a   = w_line[2*DATA_W-1:DATA_W];
    assign w_b   = w_line[DATA_W-1:0];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    always_comb begin
        w_alu   = w_sum[DATA_W-1:0];
        w_carry = 1'b0;
        unique case (r_op)
            OpAdd: begin
                w_alu   = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
            end
            OpMax: w_alu = (w_a >= w_b) ? w_a : w_b;
            OpXor: w_alu = w_a ^ w_b;
            OpMin: w_alu = (w_a <= w_b) ? w_a : w_b;
        endcase
    end

    assign w_wr_ok = bus.i_wr_en && ({1'b0, bus.i_wr_addr} < (ADDR_W+1)'(LANES));
    assign w_last  = (r_idx == ADDR_W'(LANES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_idx    <= '0;
            r_op     <= OpAdd;
            r_mem    <= '{default: '0};
            r_result <= '0;
            r_ovf    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    // A same-cycle write lands before RUN reads, so the sweep sees it.
                    if (w_wr_ok) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (bus.i_wr_addr == ADDR_W'(i)) begin
                                r_mem[i] <= bus.i_wr_data;
                            end
                        end
                    end
                    if (bus.i_start) begin
                        r_op    <= bus.i_opcode;
                        r_ovf   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    for (int i = 0; i < LANES; i++) begin
                        if (r_idx == ADDR_W'(i)) begin
                            r_result[i*DATA_W +: DATA_W] <= w_alu;
                            r_ovf[i]                     <= w_carry;
                        end
                    end
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;
    assign bus.o_result = r_result;
    assign bus.o_ovf    = r_ovf;

endmodule
